// File: rtl/io_input_periph.sv
// io_input_periph: memory-mapped switch/button input block with synchronizers, debounce, sticky press events and IRQ.
module io_input_periph #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 20,
    parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_io_sw,
    input  logic [3:0]  i_io_btn,
    input  logic        i_sel,
    input  logic [3:0]  i_addr,
    input  logic        i_wren,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_irq
);
    localparam logic [3:0] BTN_IDLE = BTN_ACTIVE_LOW ? 4'hF : 4'h0;

    logic [31:0] sw_meta, sw_sync;
    logic [3:0]  btn_meta, btn_sync, pressed, level, rise, clr, ev, irq_en;
    logic        we, unused_bits;

    // Button flops reset to the released level so reset never looks like a press.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sw_meta  <= '0;
            sw_sync  <= '0;
            btn_meta <= BTN_IDLE;
            btn_sync <= BTN_IDLE;
        end else begin
            sw_meta  <= i_io_sw;
            sw_sync  <= sw_meta;
            btn_meta <= i_io_btn;
            btn_sync <= btn_meta;
        end
    end

    assign pressed = btn_sync ^ BTN_IDLE;

    for (genvar b = 0; b < 4; b++) begin : g_btn
        logic [CNT_W-1:0] cnt;
        logic             lvl, hit, done;
        assign hit      = pressed[b] != lvl;
        assign done     = hit && (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
        assign level[b] = lvl;
        assign rise[b]  = done & ~lvl;
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                cnt <= '0;
                lvl <= 1'b0;
            end else begin
                cnt <= (hit && !done) ? cnt + 1'b1 : '0;
                if (done) lvl <= ~lvl;
            end
        end
    end

    assign we  = i_sel & i_wren;
    assign clr = (we && i_addr[3:2] == 2'd2) ? i_wdata[3:0] : 4'h0;

    // Set is OR-ed in after the clear so a same-edge press survives the W1C.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ev     <= '0;
            irq_en <= '0;
        end else begin
            ev <= (ev & ~clr) | rise;
            if (we && i_addr[3:2] == 2'd3) irq_en <= i_wdata[3:0];
        end
    end

    assign o_irq       = |(ev & irq_en);
    assign unused_bits = ^{i_addr[1:0], i_wdata[31:4]};

    always_comb begin
        o_rdata = !i_sel              ? 32'h0 :
                  i_addr[3:2] == 2'd0 ? sw_sync :
                  i_addr[3:2] == 2'd1 ? {28'h0, level} :
                  i_addr[3:2] == 2'd2 ? {28'h0, ev} :
                                        {28'h0, irq_en};
    end
endmodule

// File: tb/tb_io_input_periph.sv
// tb_io_input_periph: directed self-checking bench for io_input_periph.
module tb_io_input_periph;
    logic        clk = 1'b0;
    logic        rst, sel, wren, irq;
    logic [3:0]  addr, btn;
    logic [31:0] sw, wdata, rdata, d;
    int          tests = 0, fails = 0;

    io_input_periph dut (
        .i_clk(clk), .i_rst(rst), .i_io_sw(sw), .i_io_btn(btn), .i_sel(sel),
        .i_addr(addr), .i_wren(wren), .i_wdata(wdata), .o_rdata(rdata), .o_irq(irq)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] v);
        addr = a;
        sel  = 1'b1;
        #1;
        v = rdata;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] v);
        addr  = a;
        wdata = v;
        sel   = 1'b1;
        wren  = 1'b1;
        tick(1);
        wren  = 1'b0;
    endtask

    task automatic test_reset;
        sw = 32'hA5A5_0000; btn = 4'hF; sel = 1'b1; addr = 4'h0; wren = 1'b0; wdata = '0; rst = 1'b1;
        tick(3);
        rd(4'h0, d); tests++;
        if (d !== 32'h0) begin fails++; $display("FAIL reset_sw: got %h want %h", d, 32'h0); end
        tests++;
        if (irq !== 1'b0) begin fails++; $display("FAIL reset_irq: got %b want 0", irq); end
        rst = 1'b0;
        tick(1);
        rd(4'h0, d); tests++;
        if (d !== 32'h0) begin fails++; $display("FAIL sw_1cyc: got %h want %h", d, 32'h0); end
        tick(1);
        rd(4'h0, d); tests++;
        if (d !== 32'hA5A5_0000) begin fails++; $display("FAIL sw_2cyc: got %h want %h", d, 32'hA5A5_0000); end
        rd(4'h4, d); tests++;
        if (d !== 32'h0) begin fails++; $display("FAIL reset_level: got %h want 0", d); end
        sel = 1'b0; #1; tests++;
        if (rdata !== 32'h0) begin fails++; $display("FAIL nosel: got %h want 0", rdata); end
    endtask

    task automatic test_level_latency;
        btn = 4'hE;
        tick(17);
        rd(4'h4, d); tests++;
        if (d !== 32'h0) begin fails++; $display("FAIL level_t17: got %h want 0", d); end
        tick(1);
        rd(4'h4, d); tests++;
        if (d !== 32'h1) begin fails++; $display("FAIL level_t18: got %h want 1", d); end
        rd(4'h8, d); tests++;
        if (d !== 32'h1) begin fails++; $display("FAIL event_t18: got %h want 1", d); end
        btn = 4'hF;
        tick(20);
        rd(4'h4, d); tests++;
        if (d !== 32'h0) begin fails++; $display("FAIL release_level: got %h want 0", d); end
        rd(4'h8, d); tests++;
        if (d !== 32'h1) begin fails++; $display("FAIL release_event: got %h want 1", d); end
        wr(4'h8, 32'h1);
        rd(4'h8, d); tests++;
        if (d !== 32'h0) begin fails++; $display("FAIL w1c: got %h want 0", d); end
    endtask

    task automatic test_bounce;
        btn = 4'hD; tick(5);
        btn = 4'hF; tick(2);
        btn = 4'hD; tick(10);
        btn = 4'hF; tick(3);
        rd(4'h4, d); tests++;
        if (d !== 32'h0) begin fails++; $display("FAIL bounce_level: got %h want 0", d); end
        tick(25);
        rd(4'h4, d); tests++;
        if (d !== 32'h0) begin fails++; $display("FAIL bounce_level_late: got %h want 0", d); end
        rd(4'h8, d); tests++;
        if (d !== 32'h0) begin fails++; $display("FAIL bounce_event: got %h want 0", d); end
    endtask

    task automatic test_irq;
        wr(4'hC, 32'h1);
        btn = 4'hE;
        tick(17); tests++;
        if (irq !== 1'b0) begin fails++; $display("FAIL irq_early: got %b want 0", irq); end
        tick(1); tests++;
        if (irq !== 1'b1) begin fails++; $display("FAIL irq_set: got %b want 1", irq); end
        btn = 4'hF;
        tick(20);
        wr(4'h8, 32'h2);
        rd(4'h8, d); tests++;
        if (d !== 32'h1) begin fails++; $display("FAIL w1c_other: got %h want 1", d); end
        tests++;
        if (irq !== 1'b1) begin fails++; $display("FAIL irq_kept: got %b want 1", irq); end
        wr(4'h8, 32'h1);
        rd(4'h8, d); tests++;
        if (d !== 32'h0) begin fails++; $display("FAIL w1c_clear: got %h want 0", d); end
        tests++;
        if (irq !== 1'b0) begin fails++; $display("FAIL irq_clear: got %b want 0", irq); end
    endtask

    task automatic test_set_wins;
        btn = 4'hE;
        tick(17);
        rd(4'h8, d); tests++;
        if (d !== 32'h0) begin fails++; $display("FAIL pre_collide: got %h want 0", d); end
        wr(4'h8, 32'h1);
        rd(4'h8, d); tests++;
        if (d !== 32'h1) begin fails++; $display("FAIL set_wins: got %h want 1", d); end
        tests++;
        if (irq !== 1'b1) begin fails++; $display("FAIL set_wins_irq: got %b want 1", irq); end
        btn = 4'hF;
        tick(20);
        wr(4'h8, 32'hF);
    endtask

    task automatic test_reset_mid;
        btn = 4'hE;
        tick(12);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        rd(4'h4, d); tests++;
        if (d !== 32'h0) begin fails++; $display("FAIL mid_rst_level: got %h want 0", d); end
        rd(4'hC, d); tests++;
        if (d !== 32'h0) begin fails++; $display("FAIL mid_rst_irqen: got %h want 0", d); end
        tick(17);
        rd(4'h4, d); tests++;
        if (d !== 32'h0) begin fails++; $display("FAIL mid_rst_t17: got %h want 0", d); end
        tick(1);
        rd(4'h4, d); tests++;
        if (d !== 32'h1) begin fails++; $display("FAIL mid_rst_t18: got %h want 1", d); end
        btn = 4'hF;
        tick(20);
        wr(4'h8, 32'hF);
    endtask

    task automatic test_ro_writes;
        sw = 32'h0;
        tick(3);
        wr(4'h0, 32'hFFFF_FFFF);
        tick(2);
        rd(4'h0, d); tests++;
        if (d !== 32'h0) begin fails++; $display("FAIL sw_ro: got %h want 0", d); end
        wr(4'h4, 32'hF);
        rd(4'h4, d); tests++;
        if (d !== 32'h0) begin fails++; $display("FAIL level_ro: got %h want 0", d); end
        wr(4'hC, 32'hFFFF_FFFF);
        rd(4'hC, d); tests++;
        if (d !== 32'hF) begin fails++; $display("FAIL irqen_mask: got %h want f", d); end
    endtask

    initial begin
        test_reset;
        test_level_latency;
        test_bounce;
        test_irq;
        test_set_wins;
        test_reset_mid;
        test_ro_writes;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/io_input_periph.md
Name: io_input_periph

Overview:
- Memory-mapped input peripheral: the input-side counterpart to the CPU's LED/HEX/LCD output path.
- Captures board switches (i_io_sw) and buttons (i_io_btn) for the single-cycle core's LSU.
- Per input: double-flop synchronization; per button: debounce, sticky press-event latching, maskable interrupt.
- Sits behind the LSU I/O decode; LSU reads are combinational (same cycle, required by the single-cycle core).

Parameters:
- DEBOUNCE_CYCLES, 16, consecutive cycles of disagreement needed before the debounced level changes (≥2; board build overrides to 500000).
- CNT_W, 20, debounce counter width; must hold DEBOUNCE_CYCLES.
- BTN_ACTIVE_LOW, 1, 1 = raw button reads 0 when pressed.

Ports:
- i_clk  input  1  clock, rising edge
- i_rst  input  1  synchronous reset, active-high
- i_io_sw  input  32  raw switches, asynchronous
- i_io_btn  input  4  raw buttons, asynchronous
- i_sel  input  1  LSU access targets this block
- i_addr  input  4  byte offset; bits [3:2] select register, bits [1:0] ignored
- i_wren  input  1  write strobe, qualified by i_sel
- i_wdata  input  32  write data
- o_rdata  output  32  read data, combinational from i_sel/i_addr and registered state
- o_irq  output  1  OR of (BTN_EVENT & IRQ_EN)

Behaviour:
- Register map (offset: register, access, function):
  - 0x0: SW, RO, synchronized switches [31:0].
  - 0x4: BTN_LEVEL, RO, debounced pressed-levels in [3:0]; [31:4] = 0.
  - 0x8: BTN_EVENT, W1C, sticky press events in [3:0].
  - 0xC: IRQ_EN, RW, bits [3:0]; upper bits read 0, writes to them ignored.
- o_rdata = 0 when i_sel = 0.
- Writes to RO registers are ignored.
- Reset on an edge with i_rst = 1 (all state):
  - Switch sync flops = 0.
  - Button sync flops = released value (all 1s when BTN_ACTIVE_LOW), so no spurious press.
  - Debounce counters = 0; BTN_LEVEL = 0; BTN_EVENT = 0; IRQ_EN = 0.
  - o_irq = 0 and o_rdata = 0 for the following cycle (given i_sel = 0).
  - Reset mid-debounce discards partial counts.
- Synchronizer: two flops per bit. A stable raw change at edge k appears in the sync output after edge k+1; SW readback changes 2 cycles after the raw change.
- Button normalization: pressed = sync XOR BTN_ACTIVE_LOW.
- Debounce, per button, independent:
  - Two states: RELEASED (level 0) and PRESSED (level 1).
  - When pressed ≠ level: counter increments.
  - When pressed == level: counter clears to 0.
  - When the counter would reach DEBOUNCE_CYCLES: level toggles and the counter clears.
  - A bounce shorter than DEBOUNCE_CYCLES never changes the level.
  - Latency from a stable raw edge to the BTN_LEVEL change = DEBOUNCE_CYCLES + 2 cycles.
- Event latch:
  - On the edge where level goes 0→1, BTN_EVENT[i] is set.
  - Release (1→0) sets nothing.
  - W1C: write with i_sel & i_wren & offset 0x8 clears the bits where i_wdata = 1.
  - If a set and a clear hit the same bit on the same edge, set wins.
- IRQ: o_irq is combinational from the BTN_EVENT and IRQ_EN registers. It deasserts the cycle after the W1C clear edge, unless a new event arrived.
- Switches are not debounced.
- Counters saturate by construction: they clear on toggle, so no wrap-around.

Test Plan:
- Reset, sw = 0xA5A5_0000, btn = 4'hF, i_sel = 1:
  - Read 0x0 → 0x0000_0000 during reset.
  - 0xA5A5_0000 exactly 2 cycles after reset deasserts.
  - BTN_LEVEL = 0; o_irq = 0.
- btn[0] driven 0 continuously from cycle t:
  - BTN_LEVEL reads 0x1 at t+18 and 0x0 at t+17.
  - BTN_EVENT = 0x1 at t+18.
- btn[1] bounce: low 5 cycles, high 2, low 10, then high:
  - BTN_LEVEL[1] never sets; BTN_EVENT stays 0.
- IRQ_EN = 0x1 written, then btn[0] pressed → o_irq = 1.
  - Write 0x8 ← 0x1 → BTN_EVENT = 0 and o_irq = 0 the next cycle.
  - Write 0x8 ← 0x2 first → no effect.
- Press completing on the same edge as a W1C of that bit → BTN_EVENT bit remains 1.
- Reset asserted at count 10 of a 16-cycle debounce, then btn held pressed:
  - Level sets 18 cycles after reset release, not earlier.
- Write 0x0 ← 0xFFFF_FFFF with sw = 0 → SW still reads 0.
- Write 0xC ← 0xFFFF_FFFF → IRQ_EN reads 0xF.
